// File: rtl/spi_pixel_rx.sv
// SPI mode-0 slave that turns MCU framebuffer commands into single-cycle write strobes.
// Optional pixel write counter enabled with SPI_PIXEL_COUNT_EN.
module spi_pixel_rx #(
  parameter int FB_DEPTH = 19200,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              sdi,
  input  logic              load,
  output logic              sdo,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
`ifdef SPI_PIXEL_COUNT_EN
  output logic [15:0]       pix_count,
`endif
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OPCODE  = 3'd1,
    ADDR_HI = 3'd2,
    ADDR_LO = 3'd3,
    PIX_HI  = 3'd4,
    PIX_LO  = 3'd5,
    IGNORE  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIM  = ADDR_W'(FB_DEPTH);

  state_t              state_q, state_d;
  logic                sck_m_q, sck_s_q, sck_d_q;
  logic                sdi_m_q, sdi_s_q;
  logic                load_m_q, load_s_q;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                byte_vld_q, byte_vld_d;
  logic [7:0]          echo_q, echo_d;
  logic                sdo_q, sdo_d;
  logic [ADDR_W-9:0]   addr_hi_q, addr_hi_d;
  logic [3:0]          pix_hi_q, pix_hi_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_full;
  logic                rise, fall;
`ifdef SPI_PIXEL_COUNT_EN
  logic [15:0]         pix_count_q, pix_count_d;
`endif

  assign rise      = sck_s_q & ~sck_d_q;
  assign fall      = ~sck_s_q & sck_d_q;
  assign addr_full = {addr_hi_q, shift_q};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_vld_d = 1'b0;
    echo_d     = echo_q;
    sdo_d      = sdo_q;
    addr_hi_d  = addr_hi_q;
    pix_hi_d   = pix_hi_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
`ifdef SPI_PIXEL_COUNT_EN
    pix_count_d = pix_count_q;
`endif

    // Address advances the cycle after a strobe, independent of framing.
    if (we_q) begin
      waddr_d = (waddr_q == ADDR_LAST) ? '0 : waddr_q + ADDR_W'(1);
`ifdef SPI_PIXEL_COUNT_EN
      if (pix_count_q != 16'hFFFF) pix_count_d = pix_count_q + 16'd1;
`endif
    end

    if (!load_s_q) begin
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      echo_d    = '0;
      sdo_d     = 1'b0;
    end else begin
      if (rise) begin
        shift_d   = {shift_q[6:0], sdi_s_q};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) byte_vld_d = 1'b1;
      end

      if (state_q == IDLE) state_d = OPCODE;

      // shift_q holds the completed byte during the cycle after its last rise.
      if (byte_vld_q) begin
        echo_d = shift_q;
        case (state_q)
          OPCODE: begin
            if (shift_q == 8'h01)      state_d = ADDR_HI;
            else if (shift_q == 8'h02) state_d = PIX_HI;
            else                       state_d = IGNORE;
          end
          ADDR_HI: begin
            addr_hi_d = shift_q[ADDR_W-9:0];
            state_d   = ADDR_LO;
          end
          ADDR_LO: begin
            waddr_d = (addr_full >= ADDR_LIM) ? '0 : addr_full;
            state_d = IGNORE;
`ifdef SPI_PIXEL_COUNT_EN
            pix_count_d = '0;
`endif
          end
          PIX_HI: begin
            pix_hi_d = shift_q[3:0];
            state_d  = PIX_LO;
          end
          PIX_LO: begin
            wdata_d = {pix_hi_q, shift_q};
            we_d    = 1'b1;
            state_d = PIX_HI;
          end
          default: state_d = state_q;
        endcase
      end

      if (bit_cnt_q == 3'd0)   sdo_d = echo_q[7];
      else if (fall)           sdo_d = echo_q[3'd7 - bit_cnt_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sck_m_q    <= 1'b0;
      sck_s_q    <= 1'b0;
      sck_d_q    <= 1'b0;
      sdi_m_q    <= 1'b0;
      sdi_s_q    <= 1'b0;
      load_m_q   <= 1'b0;
      load_s_q   <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_vld_q <= 1'b0;
      echo_q     <= '0;
      sdo_q      <= 1'b0;
      addr_hi_q  <= '0;
      pix_hi_q   <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
`ifdef SPI_PIXEL_COUNT_EN
      pix_count_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sck_m_q    <= sck;
      sck_s_q    <= sck_m_q;
      sck_d_q    <= sck_s_q;
      sdi_m_q    <= sdi;
      sdi_s_q    <= sdi_m_q;
      load_m_q   <= load;
      load_s_q   <= load_m_q;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_vld_q <= byte_vld_d;
      echo_q     <= echo_d;
      sdo_q      <= sdo_d;
      addr_hi_q  <= addr_hi_d;
      pix_hi_q   <= pix_hi_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
`ifdef SPI_PIXEL_COUNT_EN
      pix_count_q <= pix_count_d;
`endif
    end
  end

  assign sdo       = sdo_q;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign state_dbg = state_q;
`ifdef SPI_PIXEL_COUNT_EN
  assign pix_count = pix_count_q;
`endif

endmodule

// File: tb/tb_spi_pixel_rx.sv
// Directed bench for spi_pixel_rx: SPI frames in, framebuffer writes and sdo echo checked.
module tb_spi_pixel_rx;

  logic        clk;
  logic        reset;
  logic        sck;
  logic        sdi;
  logic        load;
  logic        sdo;
  logic        we;
  logic [14:0] waddr;
  logic [11:0] wdata;
  logic [2:0]  state_dbg;
`ifdef SPI_PIXEL_COUNT_EN
  logic [15:0] pix_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [26:0] exp_q[$];
  logic [26:0] got_q[$];
  logic [7:0]  rx;

  spi_pixel_rx dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .sdi       (sdi),
    .load      (load),
    .sdo       (sdo),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
`ifdef SPI_PIXEL_COUNT_EN
    .pix_count (pix_count),
`endif
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset && we) got_q.push_back({waddr, wdata});
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      sdi = b[i];
      wait_clk(8);
      r[i] = sdo;
      sck = 1'b1;
      wait_clk(8);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    spi_bits(b, 8, r);
  endtask

  task automatic start_frame();
    load = 1'b1;
    wait_clk(6);
  endtask

  task automatic end_frame();
    wait_clk(8);
    load = 1'b0;
    sdi  = 1'b0;
    wait_clk(8);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] r;
    start_frame();
    spi_byte(a, r);
    spi_byte(b, r);
    spi_byte(c, r);
    end_frame();
  endtask

  // scoreboard
  task automatic check_writes(input string tag);
    logic [26:0] e, g;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_write"}, {5'd0, g}, {5'd0, e});
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [7:0] r;
    reset = 1'b0;
    sck   = 1'b0;
    sdi   = 1'b0;
    load  = 1'b0;
    wait_clk(3);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", {17'd0, waddr}, 32'd0);
    chk("rst_wdata", {20'd0, wdata}, 32'd0);
    chk("rst_sdo", {31'd0, sdo}, 32'd0);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);
    reset = 1'b1;
    wait_clk(3);

    // addressed write
    send3(8'h01, 8'h00, 8'h10);
    chk("addr_set", {17'd0, waddr}, 32'h10);
    start_frame();
    spi_byte(8'h02, r);
    spi_byte(8'h0F, r);
    spi_byte(8'h00, r);
    spi_byte(8'h01, r);
    spi_byte(8'h23, r);
    end_frame();
    exp_q.push_back({15'h0010, 12'hF00});
    exp_q.push_back({15'h0011, 12'h123});
    check_writes("addr_wr");
    chk("addr_after", {17'd0, waddr}, 32'h12);

    // wrap at the last framebuffer word (19199 = 0x4AFF)
    send3(8'h01, 8'h4A, 8'hFF);
    chk("wrap_set", {17'd0, waddr}, 32'd19199);
    start_frame();
    spi_byte(8'h02, r);
    spi_byte(8'h0A, r);
    spi_byte(8'hBC, r);
    spi_byte(8'h01, r);
    spi_byte(8'h02, r);
    end_frame();
    exp_q.push_back({15'd19199, 12'hABC});
    exp_q.push_back({15'd0, 12'h102});
    check_writes("wrap_wr");
    chk("wrap_after", {17'd0, waddr}, 32'd1);

    // out-of-range address and unknown opcode
    send3(8'h01, 8'h7F, 8'hFF);
    chk("oor_addr", {17'd0, waddr}, 32'd0);
    send3(8'h7E, 8'h55, 8'h66);
    check_writes("unk_op");
    chk("unk_waddr", {17'd0, waddr}, 32'd0);

    // aborted pixel, then a clean write at the same address
    start_frame();
    spi_byte(8'h02, r);
    spi_byte(8'h0F, r);
    spi_bits(8'hFF, 3, r);
    end_frame();
    check_writes("abort");
    chk("abort_waddr", {17'd0, waddr}, 32'd0);
    send3(8'h02, 8'h01, 8'h23);
    exp_q.push_back({15'd0, 12'h123});
    check_writes("post_abort");
    chk("post_abort_waddr", {17'd0, waddr}, 32'd1);

    // sdo echo of the previous byte
    start_frame();
    spi_byte(8'h02, r);
    chk("echo0", {24'd0, r}, 32'h00);
    spi_byte(8'hA5, r);
    chk("echo1", {24'd0, r}, 32'h02);
    spi_byte(8'h3C, r);
    chk("echo2", {24'd0, r}, 32'hA5);
    end_frame();
    exp_q.push_back({15'd1, 12'h53C});
    check_writes("echo_wr");
    chk("echo_sdo_idle", {31'd0, sdo}, 32'd0);

    // reset in the middle of an address command
    start_frame();
    spi_byte(8'h01, r);
    spi_byte(8'h12, r);
    reset = 1'b0;
    wait_clk(2);
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_waddr", {17'd0, waddr}, 32'd0);
    chk("mid_rst_wdata", {20'd0, wdata}, 32'd0);
    chk("mid_rst_sdo", {31'd0, sdo}, 32'd0);
    chk("mid_rst_state", {29'd0, state_dbg}, 32'd0);
    load  = 1'b0;
    sdi   = 1'b0;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(4);
    got_q.delete();
    send3(8'h02, 8'h0F, 8'hFF);
    exp_q.push_back({15'd0, 12'hFFF});
    check_writes("rst_wr");
    chk("rst_wr_waddr", {17'd0, waddr}, 32'd1);
`ifdef SPI_PIXEL_COUNT_EN
    chk("pix_count", {16'd0, pix_count}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
